edge_thresh: RTL and testbench
==============================

# edge_thresh

Binarising stage downstream of the Sobel pipeline. It consumes the 8-bit gradient-magnitude video stream with its dv/hs/vs timing. Each pixel is compared against a threshold and driven out as black/white RGB. In adaptive mode the threshold is recomputed once per frame, during vertical blanking, from the mean magnitude of the previous frame; a bit-serial divider does the division.

## Interface
- COLORDEPTH, 8: magnitude and output colour width.
- SUM_W, 32: magnitude accumulator width; also the number of divider iterations.
- CNT_W, 24: active-pixel counter width.
- POL_HS, 1: hs polarity. 1 = active-high; 0 = input and output inverted internally.
- POL_VS, 1: vs polarity, same convention as POL_HS.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- mag_i  in  COLORDEPTH  gradient magnitude.
- dv_i / hs_i / vs_i  in  1 each  input timing.
- mode_i  in  1  0 = fixed threshold, 1 = adaptive threshold.
- fixed_thr_i  in  COLORDEPTH  threshold used when mode_i = 0.
- offset_i  in  COLORDEPTH  unsigned offset added to the mean in adaptive mode.
- red_o / green_o / blue_o  out  COLORDEPTH each  binarised pixel.
- dv_o / hs_o / vs_o  out  1 each  delayed timing, in native polarity.
- thr_o  out  COLORDEPTH  current adaptive threshold.
- mean_o  out  COLORDEPTH  last computed frame mean.
- busy_o  out  1  high while in DIVIDE or UPDATE.

## Operation
- Internal hs/vs are polarity-normalised to active-high; outputs are re-inverted per POL_HS/POL_VS.
- Effective threshold: thr = mode_i ? thr_o : fixed_thr_i, sampled each cycle.
- Pixel output:
  - dv_i=1 and mag_i >= thr: red/green/blue = all-ones.
  - Otherwise: all zero.
- FSM, four states:
  - WAIT_VS: entered at reset. Nothing is accumulated. The first vs rising edge moves to ACCUM.
  - ACCUM: on each dv_i cycle, sum += mag_i and cnt += 1; both saturate at all-ones. A vs rising edge latches sum/cnt into the divider and clears the accumulators in that same cycle.
    - If the latched cnt == 0: stay in ACCUM; mean_o and thr_o are unchanged.
    - Otherwise: go to DIVIDE.
  - DIVIDE: restoring division, one quotient bit per cycle, SUM_W cycles.
    - Accumulation for the new frame continues in parallel.
    - vs edges seen here are dropped; the following statistics then cover more than one frame.
  - UPDATE (1 cycle):
    - mean = min(quotient, 2^COLORDEPTH−1).
    - target = min(mean + offset_i, 2^COLORDEPTH−1).
    - mean_o ← mean; thr_o ← target (or the smoothed value, see Configuration). Return to ACCUM.
- A dv_i arriving during DIVIDE/UPDATE uses the old thr_o.
- A reset mid-frame or mid-divide aborts everything and returns to WAIT_VS.

## Timing
- Pixel path latency: 1 clock. dv_o/hs_o/vs_o/RGB are registered together from the same input cycle.
- vs edge → UPDATE: 1 + SUM_W clocks. The new thr_o is applied from the cycle after UPDATE.
- Adaptive-threshold latency: one frame. Statistics of frame N set the threshold for frame N+1.
- Reset values:
  - RGB, dv_o, mean_o = 0; busy_o = 0; thr_o = 2^(COLORDEPTH−1) (0x80).
  - hs_o/vs_o at their deasserted level: 0 if POL=1, 1 if POL=0.
  - sum = cnt = 0; state = WAIT_VS.

## Configuration
- EDGE_THRESH_IIR_EN defined: UPDATE smooths the threshold, thr_o ← thr_o − (thr_o>>2) + (target>>2), truncating. This limits flicker between frames.
- EDGE_THRESH_IIR_EN undefined: thr_o ← target directly. No smoothing logic is present.

## Test plan
- Reset: assert rst low mid-ACCUM with dv active → all outputs at their reset values immediately; after release, the first frame is not accumulated until a vs edge is seen.
- Fixed mode: mode_i=0, fixed_thr_i=100, mag_i sequence 99,100,101 with dv=1 → RGB 0x00, 0xFF, 0xFF, each one clock later; dv/hs/vs delayed exactly one clock.
- Adaptive mode, IIR off: sync vs, then 16 pixels of 40, offset_i=10, then vs → busy_o for SUM_W+1 clocks, then mean_o=40, thr_o=50. With EDGE_THRESH_IIR_EN defined, thr_o=108 instead (from 0x80).
- Empty frame: two vs edges with no dv between them → no DIVIDE, busy_o stays 0, thr_o/mean_o unchanged.
- Saturation: frame of all-255 magnitudes, offset_i=20 → mean_o=255, thr_o=255 (IIR off); next frame mag 255 → 0xFF, mag 254 → 0x00.
- vs during DIVIDE: a second vs edge 5 clocks after the first → ignored; exactly one UPDATE occurs; pixels counted after the first edge appear in the next mean.

Source files
------------

// File: rtl/edge_thresh.sv
// Binarising threshold stage for a gradient-magnitude video stream.
// Optional IIR threshold smoothing is enabled by defining EDGE_THRESH_IIR_EN.
module edge_thresh #(
  parameter int COLORDEPTH = 8,
  parameter int SUM_W      = 32,
  parameter int CNT_W      = 24,
  parameter int POL_HS     = 1,
  parameter int POL_VS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] mag_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  mode_i,
  input  logic [COLORDEPTH-1:0] fixed_thr_i,
  input  logic [COLORDEPTH-1:0] offset_i,
  output logic [COLORDEPTH-1:0] red_o,
  output logic [COLORDEPTH-1:0] green_o,
  output logic [COLORDEPTH-1:0] blue_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [COLORDEPTH-1:0] thr_o,
  output logic [COLORDEPTH-1:0] mean_o,
  output logic                  busy_o
);

  localparam int ITER_W = $clog2(SUM_W + 1);
  localparam logic [COLORDEPTH-1:0] THR_RST = {1'b1, {(COLORDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {WAIT_VS, ACCUM, DIVIDE, UPDATE} state_t;

  state_t                  state_reg;
  logic                    vs_prev_reg;
  logic [SUM_W-1:0]        sum_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [SUM_W-1:0]        quo_reg;
  logic [CNT_W-1:0]        rem_reg;
  logic [CNT_W-1:0]        den_reg;
  logic [ITER_W-1:0]       iter_reg;

  logic                    hs_int;
  logic                    vs_int;
  logic                    vs_rise;
  logic [COLORDEPTH-1:0]   thr_eff;
  logic                    pix_on;
  logic [SUM_W:0]          sum_add;
  logic [SUM_W-1:0]        sum_inc;
  logic [CNT_W:0]          cnt_add;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W:0]          rem_shift;
  logic                    div_ge;
  logic [CNT_W-1:0]        rem_next;
  logic [COLORDEPTH-1:0]   mean_val;
  logic [COLORDEPTH:0]     tgt_add;
  logic [COLORDEPTH-1:0]   target;
  logic [COLORDEPTH-1:0]   thr_new;

  assign hs_int  = (POL_HS != 0) ? hs_i : ~hs_i;
  assign vs_int  = (POL_VS != 0) ? vs_i : ~vs_i;
  assign vs_rise = vs_int & ~vs_prev_reg;

  assign thr_eff = mode_i ? thr_o : fixed_thr_i;
  assign pix_on  = dv_i && (mag_i >= thr_eff);

  // Saturating accumulators: the carry-out selects all-ones.
  assign sum_add = {1'b0, sum_reg} + (SUM_W+1)'(mag_i);
  assign sum_inc = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
  assign cnt_add = {1'b0, cnt_reg} + (CNT_W+1)'(1);
  assign cnt_inc = cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];

  // Restoring divider step: dividend bits shift out of quo_reg as quotient bits shift in.
  assign rem_shift = {rem_reg, quo_reg[SUM_W-1]};
  assign div_ge    = rem_shift >= {1'b0, den_reg};
  assign rem_next  = div_ge ? CNT_W'(rem_shift - {1'b0, den_reg}) : rem_shift[CNT_W-1:0];

  assign mean_val = (|quo_reg[SUM_W-1:COLORDEPTH]) ? '1 : quo_reg[COLORDEPTH-1:0];
  assign tgt_add  = {1'b0, mean_val} + {1'b0, offset_i};
  assign target   = tgt_add[COLORDEPTH] ? '1 : tgt_add[COLORDEPTH-1:0];

`ifdef EDGE_THRESH_IIR_EN
  assign thr_new = thr_o - (thr_o >> 2) + (target >> 2);
`else
  assign thr_new = target;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      dv_o    <= 1'b0;
      hs_o    <= (POL_HS != 0) ? 1'b0 : 1'b1;
      vs_o    <= (POL_VS != 0) ? 1'b0 : 1'b1;
    end else begin
      red_o   <= pix_on ? '1 : '0;
      green_o <= pix_on ? '1 : '0;
      blue_o  <= pix_on ? '1 : '0;
      dv_o    <= dv_i;
      hs_o    <= (POL_HS != 0) ? hs_int : ~hs_int;
      vs_o    <= (POL_VS != 0) ? vs_int : ~vs_int;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= WAIT_VS;
      vs_prev_reg <= 1'b0;
      sum_reg     <= '0;
      cnt_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      den_reg     <= '0;
      iter_reg    <= '0;
      busy_o      <= 1'b0;
      thr_o       <= THR_RST;
      mean_o      <= '0;
    end else begin
      vs_prev_reg <= vs_int;

      // Accumulation runs in every state but WAIT_VS, including during division.
      if (state_reg != WAIT_VS && dv_i) begin
        sum_reg <= sum_inc;
        cnt_reg <= cnt_inc;
      end

      case (state_reg)
        WAIT_VS: begin
          if (vs_rise) state_reg <= ACCUM;
        end
        ACCUM: begin
          if (vs_rise) begin
            sum_reg <= '0;
            cnt_reg <= '0;
            if (cnt_reg != '0) begin
              quo_reg   <= sum_reg;
              den_reg   <= cnt_reg;
              rem_reg   <= '0;
              iter_reg  <= '0;
              busy_o    <= 1'b1;
              state_reg <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          quo_reg  <= {quo_reg[SUM_W-2:0], div_ge};
          rem_reg  <= rem_next;
          iter_reg <= iter_reg + 1'b1;
          if (iter_reg == ITER_W'(SUM_W - 1)) state_reg <= UPDATE;
        end
        UPDATE: begin
          mean_o    <= mean_val;
          thr_o     <= thr_new;
          busy_o    <= 1'b0;
          state_reg <= ACCUM;
        end
        default: state_reg <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_thresh.sv
// Scoreboard bench for edge_thresh: pixel expectations are queued at drive time
// and popped one clock later; threshold/mean updates are checked after each divide.
`timescale 1ns/1ps
module tb_edge_thresh;
  localparam int CD = 8;
  localparam int SW = 32;
  localparam int CW = 24;

  typedef logic [26:0] pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CD-1:0] mag_i = '0;
  logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, mode_i = 1'b0;
  logic [CD-1:0] fixed_thr_i = '0, offset_i = '0;
  logic [CD-1:0] red_o, green_o, blue_o, thr_o, mean_o;
  logic          dv_o, hs_o, vs_o, busy_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t exp_q[$];
  pix_t mon_exp;
  int   model_thr = 128;
  int   exp_mean;
  logic cfg_mode = 1'b0;
  int   cfg_fthr = 100;
  int   cfg_off  = 10;

  edge_thresh #(.COLORDEPTH(CD), .SUM_W(SW), .CNT_W(CW), .POL_HS(1), .POL_VS(1)) dut (
    .clk(clk), .rst(rst), .mag_i(mag_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .mode_i(mode_i), .fixed_thr_i(fixed_thr_i), .offset_i(offset_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .thr_o(thr_o), .mean_o(mean_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic int next_thr(input int mean, input int off);
    int tgt;
    tgt = (mean + off > 255) ? 255 : mean + off;
`ifdef EDGE_THRESH_IIR_EN
    return model_thr - (model_thr >> 2) + (tgt >> 2);
`else
    return tgt;
`endif
  endfunction

  // Drive one pixel cycle and queue the expected registered output.
  task automatic tick(input int mag, input logic dv, input logic hs, input logic vs);
    logic [CD-1:0] thr;
    logic [CD-1:0] m;
    @(negedge clk);
    mag_i       = mag[CD-1:0];
    dv_i        = dv;
    hs_i        = hs;
    vs_i        = vs;
    mode_i      = cfg_mode;
    fixed_thr_i = cfg_fthr[CD-1:0];
    offset_i    = cfg_off[CD-1:0];
    thr = cfg_mode ? model_thr[CD-1:0] : cfg_fthr[CD-1:0];
    m   = mag[CD-1:0];
    exp_q.push_back({(dv && m >= thr) ? 24'hFFFFFF : 24'h000000, dv, hs, vs});
  endtask

  // Count busy cycles over a bounded window, then compare.
  task automatic wait_update(input string tag, input int exp_busy);
    int cnt;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy_o) cnt++;
    end
    check_val(tag, cnt, exp_busy);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check_val("pixel", {5'b0, red_o, green_o, blue_o, dv_o, hs_o, vs_o}, {5'b0, mon_exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_pix", {5'b0, red_o, green_o, blue_o, dv_o, hs_o, vs_o}, 32'h0);
    check_val("rst_thr", thr_o, 32'h80);
    check_val("rst_mean", mean_o, 32'h0);
    check_val("rst_busy", busy_o, 32'h0);
    rst = 1'b1;

    // Fixed threshold, still in WAIT_VS so none of this is accumulated.
    cfg_fthr = 100;
    tick(99, 1, 0, 0);
    tick(100, 1, 0, 0);
    tick(101, 1, 1, 0);
    tick(0, 0, 1, 0);
    cfg_fthr = 0;
    tick(0, 1, 0, 0);
    tick(255, 0, 0, 0);
    cfg_fthr = 255;
    tick(254, 1, 0, 0);
    tick(255, 1, 0, 0);

    // First vs edge only arms accumulation.
    tick(0, 0, 0, 1);
    wait_update("wait_vs_busy", 0);
    tick(0, 0, 0, 0);

    // Adaptive frame of 16 x 40.
    cfg_mode = 1'b1;
    cfg_off  = 10;
    for (int i = 0; i < 16; i++) tick(40, 1, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("busy_len", SW + 1);
    check_val("mean_40", mean_o, 40);
    model_thr = next_thr(40, 10);
    check_val("thr_40", thr_o, model_thr);

    // Empty frame: no divide, nothing changes.
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("empty_busy", 0);
    check_val("empty_mean", mean_o, 40);
    check_val("empty_thr", thr_o, model_thr);

    // Pixels straddling the adaptive threshold; their mean equals it.
    tick(0, 0, 0, 0);
    exp_mean = model_thr;
    tick(model_thr - 1, 1, 0, 0);
    tick(model_thr, 1, 0, 0);
    tick(model_thr + 1, 1, 0, 0);

    // Second vs edge 5 clocks into the divide is dropped.
    tick(0, 0, 0, 1);
    tick(200, 1, 0, 0);
    tick(200, 1, 0, 0);
    tick(200, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("div_vs_busy", SW + 1 - 5);
    check_val("div_vs_mean", mean_o, exp_mean);
    model_thr = next_thr(exp_mean, 10);
    check_val("div_vs_thr", thr_o, model_thr);

    // Pixels taken during that divide form the next mean.
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("carry_busy", SW + 1);
    check_val("carry_mean", mean_o, 200);
    model_thr = next_thr(200, 10);
    check_val("carry_thr", thr_o, model_thr);

    // Saturation.
    cfg_off = 20;
    tick(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(255, 1, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("sat_busy", SW + 1);
    check_val("sat_mean", mean_o, 255);
    model_thr = next_thr(255, 20);
    check_val("sat_thr", thr_o, model_thr);
    tick(0, 0, 0, 0);
    tick(255, 1, 0, 0);
    tick(254, 1, 0, 0);

    // Asynchronous reset mid-frame with dv active.
    tick(77, 1, 1, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("arst_pix", {5'b0, red_o, green_o, blue_o, dv_o, hs_o, vs_o}, 32'h0);
    check_val("arst_thr", thr_o, 32'h80);
    check_val("arst_mean", mean_o, 32'h0);
    check_val("arst_busy", busy_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_thr = 128;
    cfg_off = 10;

    // Pixels before the first vs after reset must not be counted.
    tick(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(10, 1, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("post_rst_busy", 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(60, 1, 0, 0);
    tick(0, 0, 0, 1);
    wait_update("post_rst_div", SW + 1);
    check_val("post_rst_mean", mean_o, 60);
    model_thr = next_thr(60, 10);
    check_val("post_rst_thr", thr_o, model_thr);

    tick(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check_val("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
